// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory request/response, decode output and redirect signals of the prefetch stage.
interface fetch_queue_if #(parameter int ADDR_W = 12);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready, redirect, redirect_pc
  );
  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch with a PC-tagged FIFO, one outstanding memory read and redirect flush.
module fetch_queue #(
  parameter int                ADDR_W   = 12,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t            state;
  logic [ADDR_W-1:0] fetch_pc, req_addr;
  logic              drop;
  logic [PW:0]       count, count_nx;
  logic [PW-1:0]     rptr, wptr;
  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic              hs, rsp, push, pop;
  assign hs       = state == REQ && bus.mem_req_ready;
  assign rsp      = state == WAIT && bus.mem_rsp_valid;
  assign push     = rsp && !drop && !bus.redirect;
  assign pop      = bus.instr_valid && bus.instr_ready && !bus.redirect;
  assign count_nx = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign bus.mem_req_valid = state == REQ;
  assign bus.mem_req_addr  = req_addr;
  assign bus.instr_valid   = count != '0;
  assign bus.instr         = bus.instr_valid ? data_q[rptr] : '0;
  assign bus.instr_pc      = bus.instr_valid ? pc_q[rptr] : '0;
  always_ff @(posedge clk)
    if (push) begin
      data_q[wptr] <= bus.mem_rsp_data;
      pc_q[wptr]   <= req_addr;
      assert (count != FULL);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      drop     <= 1'b0;
      count    <= '0;
      rptr     <= '0;
      wptr     <= '0;
    end else if (bus.redirect) begin
      count    <= '0;
      rptr     <= '0;
      wptr     <= '0;
      fetch_pc <= bus.redirect_pc;
      // a bus request already shown must finish at its old address; its data is discarded
      if (state == IDLE || rsp) begin
        state    <= REQ;
        req_addr <= bus.redirect_pc;
        drop     <= 1'b0;
      end else begin
        drop <= 1'b1;
        if (hs) state <= WAIT;
      end
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count_nx;
      case (state)
        REQ:
          if (hs) begin
            state <= WAIT;
            if (!drop) fetch_pc <= fetch_pc + 1'b1;
          end
        WAIT:
          if (rsp) begin
            drop <= 1'b0;
            if (count_nx < FULL) begin
              state    <= REQ;
              req_addr <= fetch_pc;
            end else state <= IDLE;
          end
        default:
          if (count < FULL) begin
            state    <= REQ;
            req_addr <= fetch_pc;
          end
      endcase
    end
endmodule
